full_logic_n: RTL and testbench
===============================

Name: full_logic_n

Overview:
Parametrised successor of the two-destination full-logic transmission block. It steers an input word stream into N_CH destination FIFOs. The channel is selected by the word's MSBs. A control FSM handles RESET/INIT/IDLE/ACTIVE/ERROR, runtime-loaded watermarks and a backpressure output. It sits between the upstream virtual-channel stage and the per-destination consumers of the transmission layer.

Parameters:
DATA_W, 6, word width including channel-select bits
ADDR_W, 2, FIFO address width; DEPTH = 2**ADDR_W per channel
CH_SEL_W, 1, channel-select width; N_CH = 2**CH_SEL_W
TH_W, ADDR_W+1, width of watermark thresholds and occupancy counters

Ports:
clk  in  1  single clock, all logic on posedge
reset  in  1  synchronous, active-high; clears all state
init  in  1  configuration request; thresholds latched while in INIT
wr_enable  in  1  push data_in this cycle
data_in  in  DATA_W  word; channel = data_in[DATA_W-1 -: CH_SEL_W]
pop  in  N_CH  per-channel read request
umbral_alto  in  TH_W  almost-full threshold (shared by all channels)
umbral_bajo  in  TH_W  almost-empty threshold
data_out  out  N_CH*DATA_W  channel i at [i*DATA_W +: DATA_W], registered
empty, full, almost_full, almost_empty  out  N_CH each  per-channel flags
pause_out  out  1  OR of almost_full; upstream must stop writing
idle_out, active_out, error_out  out  1 each  FSM state indicators
error_ch  out  N_CH  sticky per-channel over/underflow flag

Behaviour:
- Reset (synchronous, reset=1 at posedge):
  - FSM enters RESET; all FIFO pointers and counts are 0.
  - data_out=0, error_ch=0, error_out=0, idle_out=0, active_out=0.
  - empty=all 1, full=0, almost_empty=all 1, almost_full=0, pause_out=0.
  - Latched thresholds default to alto=DEPTH-1, bajo=1.
  - reset wins over every other input.
- FSM:
  - RESET->INIT on the first cycle with reset=0.
  - INIT: thresholds are captured every cycle while init=1. On init=0, go to IDLE if latched bajo<alto and alto<=DEPTH; otherwise go to ERROR (error_ch unchanged).
  - IDLE->ACTIVE when wr_enable=1 or any FIFO is non-empty.
  - ACTIVE->IDLE when all FIFOs are empty and wr_enable=0.
  - IDLE/ACTIVE->INIT when init=1. FIFO contents are kept; new thresholds take effect on exit.
  - IDLE/ACTIVE->ERROR on any overflow or underflow event.
  - ERROR is sticky until reset.
  - idle_out/active_out/error_out are registered one-hot decodes of the state.
- Write:
  - Accepted only in IDLE/ACTIVE; dropped silently in RESET/INIT/ERROR.
  - Overflow: a push to a full channel with no same-cycle pop on that channel. The word is dropped, error_ch[ch] is set and the FSM goes to ERROR.
- Pop:
  - Served in IDLE/ACTIVE. data_out[i] updates at the posedge where pop[i]=1 (1-cycle latency) and holds otherwise.
  - Underflow: a pop on an empty channel. There is no bypass, even with a same-cycle push. data_out is held, error_ch[i] is set and the FSM goes to ERROR.
  - In ERROR, pops are ignored and data_out is held.
- Simultaneous push and pop on one channel: both take effect and the count is unchanged, including when the FIFO is full.
- Flags:
  - Counts are TH_W bits.
  - full = count==DEPTH; empty = count==0.
  - almost_full = count>=alto; almost_empty = count<=bajo.
  - All flags are derived combinationally from registered counts.
  - Pointers wrap modulo DEPTH.
- pause_out is advisory; writes while pause_out=1 are still accepted until full.

Decomposition:
- Package full_logic_pkg holds the state encoding (RESET, INIT, IDLE, ACTIVE, ERROR as 3-bit localparams) and the default-threshold functions.
- Sub-module fifo_param (DATA_W, ADDR_W) is instantiated N_CH times in a generate loop. It provides push, pop, data_out, count, empty and full.
- The top level holds the FSM, demux, threshold registers, error logic and flag comparators.

Test Plan:
- Config sequence: reset 3 cycles; init=1 with alto=3, bajo=1; then init=0 -> RESET, INIT, IDLE in order; idle_out=1; empty=2'b11.
- Steering and latency: push 6'h05 then 6'h25 -> count0=1, count1=1, active_out=1. Pop both next cycle -> data_out ch0=6'h05, ch1=6'h25 one cycle later; back to IDLE.
- Watermarks/wrap: with alto=3, push 3 words to ch0 -> almost_full[0]=1, pause_out=1. Push a 4th -> full[0]=1. Then pop/push 6 words -> FIFO order preserved across pointer wrap.
- Full push+pop: ch0 full; push 6'h0A and pop in the same cycle -> count stays 4, no error; 6'h0A is read out last.
- Errors: push to full ch1 -> error_ch=2'b10, error_out=1, word dropped, later writes ignored. Pop on empty ch0 after a fresh config -> error_ch[0]=1. Reset clears both.
- Bad config: init with alto=1, bajo=2 -> ERROR immediately after init falls; reset mid-ACTIVE with 2 words queued -> all empty next cycle.

Source files
------------

// File: rtl/full_logic_n_pkg.sv
// full_logic_pkg: control FSM state encoding and default watermark helpers for full_logic_n
package full_logic_pkg;
    localparam logic [2:0] L_RESET  = 3'd0;
    localparam logic [2:0] L_INIT   = 3'd1;
    localparam logic [2:0] L_IDLE   = 3'd2;
    localparam logic [2:0] L_ACTIVE = 3'd3;
    localparam logic [2:0] L_ERROR  = 3'd4;
    typedef enum logic [2:0] {
        ST_RESET  = L_RESET,
        ST_INIT   = L_INIT,
        ST_IDLE   = L_IDLE,
        ST_ACTIVE = L_ACTIVE,
        ST_ERROR  = L_ERROR
    } state_t;
    function automatic int def_alto(int depth);
        return depth - 1;
    endfunction
    function automatic int def_bajo();
        return 1;
    endfunction
endpackage

// File: rtl/full_logic_n_if.sv
// full_logic_n_if: write/pop/threshold inputs and data/flag/state outputs of full_logic_n
// master drives init, wr_enable, data_in, pop, umbral_alto, umbral_bajo; slave drives the rest.
interface full_logic_n_if #(
    parameter int DATA_W   = 6,
    parameter int CH_SEL_W = 1,
    parameter int TH_W     = 3
);
    localparam int N_CH = 2 ** CH_SEL_W;
    logic                   init;
    logic                   wr_enable;
    logic [DATA_W-1:0]      data_in;
    logic [N_CH-1:0]        pop;
    logic [TH_W-1:0]        umbral_alto;
    logic [TH_W-1:0]        umbral_bajo;
    logic [N_CH*DATA_W-1:0] data_out;
    logic [N_CH-1:0]        empty;
    logic [N_CH-1:0]        full;
    logic [N_CH-1:0]        almost_full;
    logic [N_CH-1:0]        almost_empty;
    logic                   pause_out;
    logic                   idle_out;
    logic                   active_out;
    logic                   error_out;
    logic [N_CH-1:0]        error_ch;
    modport master (
        output init, wr_enable, data_in, pop, umbral_alto, umbral_bajo,
        input  data_out, empty, full, almost_full, almost_empty,
               pause_out, idle_out, active_out, error_out, error_ch
    );
    modport slave (
        input  init, wr_enable, data_in, pop, umbral_alto, umbral_bajo,
        output data_out, empty, full, almost_full, almost_empty,
               pause_out, idle_out, active_out, error_out, error_ch
    );
endinterface

// File: rtl/full_logic_n_fifo.sv
// fifo_param: single-clock FIFO with registered read port that updates only on pop
// Ports: clk, reset (sync, active-high), push/din, pop/dout, count, empty, full.
// The caller never pushes to a full FIFO without a pop, nor pops an empty one.
module fifo_param #(
    parameter int DATA_W = 6,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full
);
    localparam int DEPTH = 2 ** ADDR_W;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wp, r_rp;
    logic [ADDR_W:0]   r_cnt;
    logic [DATA_W-1:0] r_dout;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_cnt  <= '0;
            r_dout <= '0;
        end else begin
            if (push) begin
                r_mem[r_wp] <= din;
                r_wp        <= r_wp + 1'b1;
            end
            if (pop) begin
                r_dout <= r_mem[r_rp];
                r_rp   <= r_rp + 1'b1;
            end
            r_cnt <= r_cnt + (ADDR_W + 1)'(push) - (ADDR_W + 1)'(pop);
        end
    end
    assign dout  = r_dout;
    assign count = r_cnt;
    assign empty = r_cnt == '0;
    assign full  = r_cnt == (ADDR_W + 1)'(DEPTH);
endmodule

// File: rtl/full_logic_n.sv
// full_logic_n: steers a word stream into N_CH FIFOs under a config/run/error FSM with watermarks
// Ports: clk, reset (sync, active-high); bus (slave) carries write, pop and threshold inputs
// plus per-channel data/flags, pause_out, state indicators and sticky error_ch.
module full_logic_n
    import full_logic_pkg::*;
#(
    parameter int DATA_W   = 6,
    parameter int ADDR_W   = 2,
    parameter int CH_SEL_W = 1,
    parameter int TH_W     = ADDR_W + 1
) (
    input  logic          clk,
    input  logic          reset,
    full_logic_n_if.slave bus
);
    localparam int N_CH  = 2 ** CH_SEL_W;
    localparam int DEPTH = 2 ** ADDR_W;
    state_t              r_state, w_next;
    logic [TH_W-1:0]     r_alto, r_bajo;
    logic [N_CH-1:0]     r_err_ch;
    logic [N_CH-1:0]     w_push, w_pop, w_ovf, w_udf, w_empty, w_full, w_af, w_ae;
    logic [CH_SEL_W-1:0] w_ch;
    logic                w_run, w_err;
    assign w_run = (r_state == ST_IDLE) || (r_state == ST_ACTIVE);
    assign w_ch  = bus.data_in[DATA_W-1 -: CH_SEL_W];
    assign w_err = |(w_ovf | w_udf);
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [DATA_W-1:0] w_dout;
        logic [ADDR_W:0]   w_cnt;
        logic              w_wr;
        assign w_wr     = w_run && bus.wr_enable && (w_ch == CH_SEL_W'(g));
        // a same-cycle pop frees the slot, so a full FIFO can still take the word
        assign w_ovf[g]  = w_wr && w_full[g] && !bus.pop[g];
        assign w_udf[g]  = w_run && bus.pop[g] && w_empty[g];
        assign w_push[g] = w_wr && !w_ovf[g];
        assign w_pop[g]  = w_run && bus.pop[g] && !w_empty[g];
        fifo_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (w_push[g]),
            .pop   (w_pop[g]),
            .din   (bus.data_in),
            .dout  (w_dout),
            .count (w_cnt),
            .empty (w_empty[g]),
            .full  (w_full[g])
        );
        assign w_af[g] = TH_W'(w_cnt) >= r_alto;
        assign w_ae[g] = TH_W'(w_cnt) <= r_bajo;
        assign bus.data_out[g*DATA_W +: DATA_W] = w_dout;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_RESET:  w_next = ST_INIT;
            ST_INIT:   if (!bus.init) w_next = (r_bajo < r_alto && r_alto <= TH_W'(DEPTH)) ? ST_IDLE : ST_ERROR;
            ST_IDLE:   w_next = w_err ? ST_ERROR : bus.init ? ST_INIT :
                                (bus.wr_enable || !(&w_empty)) ? ST_ACTIVE : ST_IDLE;
            ST_ACTIVE: w_next = w_err ? ST_ERROR : bus.init ? ST_INIT :
                                (!bus.wr_enable && &w_empty) ? ST_IDLE : ST_ACTIVE;
            ST_ERROR:  w_next = ST_ERROR;
            default:   w_next = ST_RESET;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_RESET;
            r_alto   <= TH_W'(def_alto(DEPTH));
            r_bajo   <= TH_W'(def_bajo());
            r_err_ch <= '0;
        end else begin
            r_state  <= w_next;
            r_err_ch <= r_err_ch | w_ovf | w_udf;
            if (r_state == ST_INIT && bus.init) begin
                r_alto <= bus.umbral_alto;
                r_bajo <= bus.umbral_bajo;
            end
        end
    end
    assign bus.empty        = w_empty;
    assign bus.full         = w_full;
    assign bus.almost_full  = w_af;
    assign bus.almost_empty = w_ae;
    assign bus.pause_out    = |w_af;
    assign bus.error_ch     = r_err_ch;
    assign bus.idle_out     = r_state == ST_IDLE;
    assign bus.active_out   = r_state == ST_ACTIVE;
    assign bus.error_out    = r_state == ST_ERROR;
endmodule

// File: tb/tb_full_logic_n.sv
// tb_full_logic_n: directed scoreboard bench for full_logic_n (N_CH=2, DEPTH=4)
module tb_full_logic_n;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    full_logic_n_if #(.DATA_W(6), .CH_SEL_W(1), .TH_W(3)) bus ();
    full_logic_n #(.DATA_W(6), .ADDR_W(2), .CH_SEL_W(1), .TH_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    int checks = 0;
    int errors = 0;
    logic [5:0] q0[$];
    logic [5:0] q1[$];
    logic [6:0] sb[$];
    logic m_run = 1'b0;
    int alto = 3;
    int bajo = 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int msize(input int c);
        return (c == 0) ? q0.size() : q1.size();
    endfunction

    task automatic chk_flags();
        logic [1:0] e, f, af, ae;
        for (int c = 0; c < 2; c++) begin
            e[c]  = msize(c) == 0;
            f[c]  = msize(c) == 4;
            af[c] = msize(c) >= alto;
            ae[c] = msize(c) <= bajo;
        end
        chk("empty", 32'(bus.empty), 32'(e));
        chk("full", 32'(bus.full), 32'(f));
        chk("almost_full", 32'(bus.almost_full), 32'(af));
        chk("almost_empty", 32'(bus.almost_empty), 32'(ae));
        chk("pause_out", 32'(bus.pause_out), 32'(|af));
    endtask

    task automatic step(input logic we, input logic [5:0] din, input logic [1:0] pp);
        logic err;
        logic [6:0] e;
        int c;
        err = 1'b0;
        bus.wr_enable = we;
        bus.data_in   = din;
        bus.pop       = pp;
        if (m_run) begin
            if (pp[0]) begin
                if (q0.size() > 0) sb.push_back({1'b0, q0.pop_front()});
                else err = 1'b1;
            end
            if (pp[1]) begin
                if (q1.size() > 0) sb.push_back({1'b1, q1.pop_front()});
                else err = 1'b1;
            end
            if (we) begin
                if (din[5]) begin
                    if (q1.size() < 4) q1.push_back(din);
                    else err = 1'b1;
                end else begin
                    if (q0.size() < 4) q0.push_back(din);
                    else err = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            c = int'(e[6]);
            chk("data_out", 32'(bus.data_out[c*6 +: 6]), 32'(e[5:0]));
        end
        bus.wr_enable = 1'b0;
        bus.pop       = 2'b00;
        if (err) m_run = 1'b0;
        chk_flags();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        q0.delete();
        q1.delete();
        sb.delete();
        m_run = 1'b0;
        alto = 3;
        bajo = 1;
    endtask

    task automatic cfg(input int a, input int b);
        bus.init        = 1'b1;
        bus.umbral_alto = 3'(a);
        bus.umbral_bajo = 3'(b);
        @(posedge clk);
        #1;
        chk("init_state", {29'd0, bus.idle_out, bus.active_out, bus.error_out}, 32'd0);
        @(posedge clk);
        #1;
        bus.init = 1'b0;
        @(posedge clk);
        #1;
        alto  = a;
        bajo  = b;
        m_run = (b < a) && (a <= 4);
        chk("cfg_idle", 32'(bus.idle_out), 32'(m_run));
        chk("cfg_error", 32'(bus.error_out), 32'(!m_run));
        chk_flags();
    endtask

    initial begin
        bus.init        = 1'b0;
        bus.wr_enable   = 1'b0;
        bus.data_in     = '0;
        bus.pop         = '0;
        bus.umbral_alto = '0;
        bus.umbral_bajo = '0;
        do_reset(3);
        chk("rst_state", {29'd0, bus.idle_out, bus.active_out, bus.error_out}, 32'd0);
        chk("rst_error_ch", 32'(bus.error_ch), 32'd0);
        chk("rst_data_out", 32'(bus.data_out), 32'd0);
        chk_flags();
        cfg(3, 1);
        step(1'b1, 6'h05, 2'b00);
        chk("active_after_push", 32'(bus.active_out), 32'd1);
        step(1'b1, 6'h25, 2'b00);
        step(1'b0, 6'h00, 2'b11);
        step(1'b0, 6'h00, 2'b00);
        chk("back_to_idle", 32'(bus.idle_out), 32'd1);
        for (int k = 1; k <= 4; k++) step(1'b1, 6'(k), 2'b00);
        for (int k = 1; k <= 6; k++) step(1'b1, 6'(16 + k), 2'b01);
        step(1'b1, 6'h0A, 2'b01);
        chk("full_push_pop_no_err", 32'(bus.error_out), 32'd0);
        repeat (4) step(1'b0, 6'h00, 2'b01);
        for (int k = 1; k <= 4; k++) step(1'b1, 6'(32 + k), 2'b00);
        step(1'b1, 6'h2F, 2'b00);
        chk("ovf_error_ch", 32'(bus.error_ch), 32'b10);
        chk("ovf_error_out", 32'(bus.error_out), 32'd1);
        step(1'b1, 6'h01, 2'b00);
        step(1'b0, 6'h00, 2'b10);
        chk("err_dout_held", 32'(bus.data_out[11:6]), 32'h25);
        do_reset(1);
        chk("rst_clr_error_ch", 32'(bus.error_ch), 32'd0);
        chk("rst_clr_error_out", 32'(bus.error_out), 32'd0);
        chk_flags();
        cfg(3, 1);
        step(1'b0, 6'h00, 2'b01);
        chk("udf_error_ch", 32'(bus.error_ch), 32'b01);
        chk("udf_error_out", 32'(bus.error_out), 32'd1);
        chk("udf_dout_held", 32'(bus.data_out[5:0]), 32'd0);
        do_reset(1);
        cfg(1, 2);
        do_reset(1);
        cfg(3, 1);
        step(1'b1, 6'h07, 2'b00);
        step(1'b1, 6'h27, 2'b00);
        chk("active_queued", 32'(bus.active_out), 32'd1);
        do_reset(1);
        chk_flags();
        chk("rst_mid_active", 32'(bus.active_out), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
